note_arbiter: RTL
=================

// Module: note_arbiter
// PURPOSE
//  Monophonic voice controller between the 4-key debouncer and the single PWM tone generator.
//  Tracks held keys in a last-note-priority stack and selects the newest held key.
//  Loads that key's half-period divider into the generator over a valid/ready handshake.
//  Drives the gate (tone enable) with a programmable release tail after the last key is released.
// PARAMETERS
//  DIV_DO       23860    half-period divider for key 0, in clk cycles
//  DIV_RE       21302    half-period divider for key 1
//  DIV_MI       18977    half-period divider for key 2
//  DIV_FA       17906    half-period divider for key 3
//  RELEASE_CYC  125000   gate hold after last release (5 ms at 25 MHz); 0 = no tail
// PORTS
//  clk         in   1   system clock (25 MHz)
//  rst         in   1   synchronous, active-high reset
//  btn_stable  in   4   debounced keys, bit i = key i held
//  div_ready   in   1   tone generator accepts div_out this cycle
//  div_out     out  32  divider offered to the tone generator
//  div_valid   out  1   div_out is valid; held until accepted
//  gate        out  1   tone enable
//  retrig      out  1   one-cycle pulse on each accepted divider load
//  active_key  out  2   index of the key currently sounding
// BEHAVIOUR
//  Reset: stack empty, count=0, pending masks=0, btn_prev=0, state IDLE.
//   div_out=0, div_valid=0, gate=0, retrig=0, active_key=0.
//   A key held through reset is seen as a press on the first cycle after rst falls.
//  Edge detect: press = btn_stable & ~btn_prev; release = ~btn_stable & btn_prev.
//   Edges are OR'd into pend_press and pend_rel at each edge.
//   If the same key has both bits pending, both bits are cleared (event cancelled).
//  Stack: 4 entries x 2-bit key index, plus count 0..4. One event is applied per cycle.
//   Releases are applied before presses; within a kind, the lowest key index goes first.
//   Press pushes the key to the top. Release removes the key wherever it sits; entries above it shift down.
//   Releasing a key not in the stack is a no-op. Overflow cannot occur: each key appears at most once.
//  target = top-of-stack key, valid when count>0.
//  FSM:
//   IDLE:    count>0 -> LOAD.
//   LOAD:    div_valid=1; div_out=DIV[target] is latched on entry.
//            div_out stays stable while div_valid=1, even if target changes.
//            On div_valid & div_ready: active_key<=latched key, gate<=1, retrig=1 for 1 cycle.
//            After the handshake: count==0 -> RELEASE; target!=active_key -> LOAD again; else -> PLAY.
//   PLAY:    count==0 -> RELEASE; target!=active_key -> LOAD (gate stays 1).
//   RELEASE: gate=1; count down from RELEASE_CYC.
//            count>0 -> LOAD (retrigger; gate never drops).
//            Counter expires -> IDLE with gate<=0. RELEASE_CYC=0 -> IDLE the next cycle.
//   IDLE after release: gate=0, div_valid=0, div_out and active_key keep their last values.
//  Latency, from an idle state with nothing pending:
//   btn_stable first sampled high at edge E0 -> pend set at E0 -> push at E1.
//   LOAD with div_valid=1 after E2.
//   With div_ready=1: handshake at E3; gate=1 and retrig=1 after E3.
//  rst during any state: all outputs return to reset values after the next edge; any handshake in flight is abandoned.
//  Widths: the release counter is 32-bit unsigned; dividers are 32-bit and zero-extended from the parameters.
// STRUCTURE
//  note_pkg:
//   DIV_* defaults.
//   Key index encoding: DO=0, RE=1, MI=2, FA=3.
//   FSM state enum {IDLE, LOAD, PLAY, RELEASE}.
//   Function key2div(idx).
//  Sub-module note_stack:
//   4-entry LIFO with remove-by-value.
//   Ports: push/push_key, remove/remove_key, top, count.
//  note_arbiter contains: edge detect, pending masks, event scheduler, FSM, release counter.
// TESTING (RELEASE_CYC=100 in bench; div_ready=1 unless stated)
//  Reset with no keys for 200 cycles -> div_valid=0, gate=0, retrig=0, div_out=0.
//  Press 4'b0001 -> after exactly 3 edges div_valid=1, div_out=23860; then gate=1, one retrig pulse, active_key=0.
//  Legato:
//   Hold key0, add key2 -> div_out=18977, active_key=2, gate continuous.
//   Release key2 -> reload 23860 with retrig.
//   Release key0 -> gate stays 1 for 100 cycles, then 0.
//  Simultaneous press 4'b1010 -> key1 pushed, then key3; final div_out=17906.
//   Release key3 -> div_out=21302.
//  Backpressure: div_ready=0 for 20 cycles.
//   Switch key0->key1 mid-LOAD -> div_out holds 23860 until accepted.
//   Then a second LOAD of 21302; exactly 2 retrig pulses.
//  Retrigger and reset:
//   Press key1 at cycle 50 of the release tail -> gate never drops, new retrig.
//   Assert rst in PLAY with key held -> all outputs 0 after one edge; the key is re-played after rst falls.

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and constants for the monophonic note arbiter: key encoding,
// divider table, controller state and small helper functions.
package note_pkg;

  localparam int unsigned DIV_DO_DEF  = 23860;
  localparam int unsigned DIV_RE_DEF  = 21302;
  localparam int unsigned DIV_MI_DEF  = 18977;
  localparam int unsigned DIV_FA_DEF  = 17906;
  localparam int unsigned STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    KEY_DO = 2'd0,
    KEY_RE = 2'd1,
    KEY_MI = 2'd2,
    KEY_FA = 2'd3
  } key_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    RELEASE
  } state_e;

  // Entry i holds the half-period divider of key i.
  typedef logic [3:0][31:0] div_table_t;

  function automatic logic [31:0] key2div(input logic [1:0] idx, input div_table_t tab);
    return tab[idx];
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/note_stack.sv
// Last-note-priority stack: push to the top, remove any key by value with the
// entries above it shifting down. Each key is present at most once.
module note_stack
  import note_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_key,
  input  logic       remove,
  input  logic [1:0] remove_key,
  output logic [1:0] top,
  output logic [2:0] count
);

  logic [1:0] entries [STACK_DEPTH];
  logic       hit;
  logic [2:0] hit_pos;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_pos = 3'd0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!hit && (3'(i) < count) && (entries[i] == remove_key)) begin
        hit     = 1'b1;
        hit_pos = 3'(i);
      end
    end
    top = (count != 3'd0) ? entries[2'(count - 3'd1)] : 2'd0;
  end

  // NOTE: the entry array is not reset; count alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && (count < 3'(STACK_DEPTH))) begin
      entries[count[1:0]] <= push_key;
    end else if (remove && hit) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        if (3'(i) >= hit_pos) entries[i] <= entries[i+1];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 3'd0;
    end else if (push && (count < 3'(STACK_DEPTH))) begin
      count <= count + 3'd1;
    end else if (remove && hit) begin
      count <= count - 3'd1;
    end
  end

endmodule

// File: rtl/note_arbiter.sv
// Monophonic voice controller: newest held key wins, its divider is handed to
// the tone generator over valid/ready, and the gate has a release tail.
module note_arbiter
  import note_pkg::*;
#(
  parameter int unsigned DIV_DO      = DIV_DO_DEF,
  parameter int unsigned DIV_RE      = DIV_RE_DEF,
  parameter int unsigned DIV_MI      = DIV_MI_DEF,
  parameter int unsigned DIV_FA      = DIV_FA_DEF,
  parameter int unsigned RELEASE_CYC = 125000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_stable,
  input  logic        div_ready,
  output logic [31:0] div_out,
  output logic        div_valid,
  output logic        gate,
  output logic        retrig,
  output logic [1:0]  active_key
);

  localparam div_table_t DIV_TAB = {32'(DIV_FA), 32'(DIV_MI), 32'(DIV_RE), 32'(DIV_DO)};

  logic [3:0]  btn_prev, pend_press, pend_rel;
  logic [3:0]  press_edge, rel_edge, ev_mask, nxt_press, nxt_rel, cancel;
  logic        do_remove, do_push;
  logic [1:0]  ev_key, target, load_key;
  logic [2:0]  count;
  logic        has_note;
  logic [31:0] rel_cnt;
  state_e      state;

  // Releases drain before presses, lowest key first; a key with both a press
  // and a release outstanding has its event cancelled entirely.
  always_comb begin
    press_edge = btn_stable & ~btn_prev;
    rel_edge   = ~btn_stable & btn_prev;
    do_remove  = |pend_rel;
    do_push    = !do_remove && (|pend_press);
    ev_key     = do_remove ? lowest_idx(pend_rel) : lowest_idx(pend_press);
    ev_mask    = (do_remove || do_push) ? (4'b0001 << ev_key) : 4'b0000;
    nxt_rel    = (pend_rel & ~(do_remove ? ev_mask : 4'b0000)) | rel_edge;
    nxt_press  = (pend_press & ~(do_push ? ev_mask : 4'b0000)) | press_edge;
    cancel     = nxt_press & nxt_rel;
    has_note   = (count != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev   <= 4'd0;
      pend_press <= 4'd0;
      pend_rel   <= 4'd0;
    end else begin
      btn_prev   <= btn_stable;
      pend_press <= nxt_press & ~cancel;
      pend_rel   <= nxt_rel & ~cancel;
    end
  end

  note_stack u_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (do_push),
    .push_key   (ev_key),
    .remove     (do_remove),
    .remove_key (ev_key),
    .top        (target),
    .count      (count)
  );

  // div_out/load_key are captured only on entry to LOAD, so the offered divider
  // stays stable for the whole handshake even if the target moves meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_out    <= 32'd0;
      div_valid  <= 1'b0;
      gate       <= 1'b0;
      retrig     <= 1'b0;
      active_key <= 2'd0;
      load_key   <= 2'd0;
      rel_cnt    <= 32'd0;
    end else begin
      retrig <= 1'b0;
      case (state)
        IDLE: begin
          if (has_note) begin
            state     <= LOAD;
            div_valid <= 1'b1;
            div_out   <= key2div(target, DIV_TAB);
            load_key  <= target;
          end
        end
        LOAD: begin
          if (div_valid && div_ready) begin
            active_key <= load_key;
            gate       <= 1'b1;
            retrig     <= 1'b1;
            if (!has_note) begin
              state     <= RELEASE;
              div_valid <= 1'b0;
              rel_cnt   <= 32'(RELEASE_CYC);
            end else if (target != load_key) begin
              div_out  <= key2div(target, DIV_TAB);
              load_key <= target;
            end else begin
              state     <= PLAY;
              div_valid <= 1'b0;
            end
          end
        end
        PLAY: begin
          if (!has_note) begin
            state   <= RELEASE;
            rel_cnt <= 32'(RELEASE_CYC);
          end else if (target != active_key) begin
            state     <= LOAD;
            div_valid <= 1'b1;
            div_out   <= key2div(target, DIV_TAB);
            load_key  <= target;
          end
        end
        RELEASE: begin
          if (has_note) begin
            state     <= LOAD;
            div_valid <= 1'b1;
            div_out   <= key2div(target, DIV_TAB);
            load_key  <= target;
          end else if (rel_cnt == 32'd0) begin
            state <= IDLE;
            gate  <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
